serial_io_access_sequencer: RTL and testbench

Sits directly downstream of the serial IO address decoder. Takes one port-enable output (Bluetooth or Wifi) plus the CPU bridge bus, and runs a timed 16550 UART register access: chip select, read/write strobes, register address and write data. It stalls the CPU bridge with a wait request until the UART's setup, strobe and hold times are met. One instance is used per UART port.

---
 rtl/serial_io_access_sequencer_pkg.sv | 39 +++
 rtl/serial_io_access_sequencer_phase_counter.sv | 29 ++
 rtl/serial_io_access_sequencer.sv | 168 ++++++++++++++++
 tb/tb_serial_io_access_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_io_access_sequencer_pkg.sv
// Shared types for the serial IO access sequencer.
// State encoding, 16550 register map and counter sizing.
package serial_io_access_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_ACK     = 3'd4,
    ST_RECOVER = 3'd5
  } seq_state_t;

  localparam logic [2:0] REG_RBR = 3'd0;
  localparam logic [2:0] REG_THR = 3'd0;
  localparam logic [2:0] REG_IER = 3'd1;
  localparam logic [2:0] REG_IIR = 3'd2;
  localparam logic [2:0] REG_FCR = 3'd2;
  localparam logic [2:0] REG_LCR = 3'd3;
  localparam logic [2:0] REG_MCR = 3'd4;
  localparam logic [2:0] REG_LSR = 3'd5;
  localparam logic [2:0] REG_MSR = 3'd6;
  localparam logic [2:0] REG_SCR = 3'd7;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/serial_io_access_sequencer_phase_counter.sv
// Loadable down-counter with a zero flag.
// One instance times every phase of the access.
module serial_io_phase_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // load wins over decrement; never wraps below zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/serial_io_access_sequencer.sv
// Timed 16550 register access for one UART port.
// Stalls the CPU bridge until setup/strobe/hold are met.
module serial_io_access_sequencer
  import serial_io_access_sequencer_pkg::*;
#(
  parameter int SETUP_CYCLES   = 1,
  parameter int STROBE_CYCLES  = 4,
  parameter int HOLD_CYCLES    = 1,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic       Clock,
  input  logic       Reset_L,
  input  logic       Port_Enable_H,
  input  logic       WE_L,
  input  logic [2:0] Address,
  input  logic [7:0] CPU_DataIn,
  output logic [7:0] CPU_DataOut,
  output logic       WaitRequest_H,
  output logic       UART_CS_L,
  output logic       UART_RD_L,
  output logic       UART_WR_L,
  output logic [2:0] UART_A,
  output logic [7:0] UART_DataOut,
  output logic       UART_DataOE_H,
  input  logic [7:0] UART_DataIn
);

  localparam int CW = cnt_width(SETUP_CYCLES, STROBE_CYCLES,
                                HOLD_CYCLES, RECOVER_CYCLES);

  localparam logic [CW-1:0] LD_SETUP  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] LD_STROBE = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] LD_HOLD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] LD_RECOV  =
    CW'((RECOVER_CYCLES > 0) ? RECOVER_CYCLES - 1 : 0);

  seq_state_t    state;
  logic          is_write;
  logic          cnt_load;
  logic          cnt_dec;
  logic [CW-1:0] cnt_val;
  logic          cnt_zero;

  serial_io_phase_counter #(
    .W(CW)
  ) u_phase_cnt (
    .clk     (Clock),
    .rst_n   (Reset_L),
    .load    (cnt_load),
    .dec     (cnt_dec),
    .load_val(cnt_val),
    .zero    (cnt_zero)
  );

  // counter reloads on entry to each timed phase, else counts down
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    unique case (state)
      ST_IDLE: begin
        if (Port_Enable_H) begin
          cnt_load = 1'b1;
          cnt_val  = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = LD_STROBE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = LD_HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        cnt_dec = !cnt_zero;
      end
      ST_ACK: begin
        cnt_load = (RECOVER_CYCLES > 0);
        cnt_val  = LD_RECOV;
      end
      ST_RECOVER: begin
        cnt_dec = !cnt_zero;
      end
      default: begin
        cnt_load = 1'b0;
      end
    endcase
  end

  // sequencer; outputs are registered with the state they belong to
  always_ff @(posedge Clock) begin
    if (!Reset_L) begin
      state         <= ST_IDLE;
      is_write      <= 1'b0;
      UART_CS_L     <= 1'b1;
      UART_RD_L     <= 1'b1;
      UART_WR_L     <= 1'b1;
      UART_A        <= '0;
      UART_DataOut  <= '0;
      UART_DataOE_H <= 1'b0;
      CPU_DataOut   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (Port_Enable_H) begin
            is_write      <= ~WE_L;
            UART_A        <= Address;
            UART_DataOut  <= CPU_DataIn;
            UART_DataOE_H <= ~WE_L;
            UART_CS_L     <= 1'b0;
            state         <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_zero) begin
            UART_RD_L <= is_write;
            UART_WR_L <= ~is_write;
            state     <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (cnt_zero) begin
            UART_RD_L <= 1'b1;
            UART_WR_L <= 1'b1;
            if (!is_write) begin
              CPU_DataOut <= UART_DataIn;
            end
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_zero) begin
            UART_CS_L     <= 1'b1;
            UART_DataOE_H <= 1'b0;
            state         <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (RECOVER_CYCLES > 0) begin
            state <= ST_RECOVER;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RECOVER: begin
          if (cnt_zero) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign WaitRequest_H = Port_Enable_H && (state != ST_ACK);

endmodule

// File: tb/tb_serial_io_access_sequencer.sv
// Directed bench for serial_io_access_sequencer.
// Two instances: default timing and SETUP=2/STROBE=1/HOLD=2/RECOVER=0.
module tb_serial_io_access_sequencer;

  logic       Clock = 1'b0;
  logic       Reset_L;
  logic       pe;
  logic       pe2;
  logic       WE_L;
  logic [2:0] Address;
  logic [7:0] CPU_DataIn;
  logic [7:0] UART_DataIn;

  logic [7:0] cpu_dout;
  logic       wait_h;
  logic       cs_l;
  logic       rd_l;
  logic       wr_l;
  logic [2:0] ua;
  logic [7:0] udo;
  logic       oe;

  logic [7:0] cpu_dout2;
  logic       wait2;
  logic       cs2;
  logic       rd2;
  logic       wr2;
  logic [2:0] ua2;
  logic [7:0] udo2;
  logic       oe2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 Clock = ~Clock;

  serial_io_access_sequencer u_dut (
    .Clock        (Clock),
    .Reset_L      (Reset_L),
    .Port_Enable_H(pe),
    .WE_L         (WE_L),
    .Address      (Address),
    .CPU_DataIn   (CPU_DataIn),
    .CPU_DataOut  (cpu_dout),
    .WaitRequest_H(wait_h),
    .UART_CS_L    (cs_l),
    .UART_RD_L    (rd_l),
    .UART_WR_L    (wr_l),
    .UART_A       (ua),
    .UART_DataOut (udo),
    .UART_DataOE_H(oe),
    .UART_DataIn  (UART_DataIn)
  );

  serial_io_access_sequencer #(
    .SETUP_CYCLES  (2),
    .STROBE_CYCLES (1),
    .HOLD_CYCLES   (2),
    .RECOVER_CYCLES(0)
  ) u_dut2 (
    .Clock        (Clock),
    .Reset_L      (Reset_L),
    .Port_Enable_H(pe2),
    .WE_L         (WE_L),
    .Address      (Address),
    .CPU_DataIn   (CPU_DataIn),
    .CPU_DataOut  (cpu_dout2),
    .WaitRequest_H(wait2),
    .UART_CS_L    (cs2),
    .UART_RD_L    (rd2),
    .UART_WR_L    (wr2),
    .UART_A       (ua2),
    .UART_DataOut (udo2),
    .UART_DataOE_H(oe2),
    .UART_DataIn  (UART_DataIn)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  initial begin
    Reset_L     = 1'b0;
    pe          = 1'b0;
    pe2         = 1'b0;
    WE_L        = 1'b1;
    Address     = 3'd0;
    CPU_DataIn  = 8'h00;
    UART_DataIn = 8'h00;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_cs", cs_l, 1);
    chk("rst_rd", rd_l, 1);
    chk("rst_wr", wr_l, 1);
    chk("rst_a", ua, 0);
    chk("rst_do", udo, 0);
    chk("rst_oe", oe, 0);
    chk("rst_cpu", cpu_dout, 0);
    chk("rst_wait", wait_h, 0);
    Reset_L = 1'b1;

    // write LCR = 0x83, inputs disturbed mid-access
    nxt();
    cyc = 0;
    pe = 1'b1; WE_L = 1'b0; Address = 3'd3; CPU_DataIn = 8'h83;
    #1;
    chk("wr_wait0", wait_h, 1);
    chk("wr_cs0", cs_l, 1);
    for (int c = 1; c <= 9; c++) begin
      nxt();
      if (c == 3) begin
        Address = 3'd6; CPU_DataIn = 8'h00; WE_L = 1'b1;
      end
      if (c == 8) pe = 1'b0;
      #1;
      chk("wr_cs", cs_l, (c <= 6) ? 0 : 1);
      chk("wr_wr", wr_l, (c >= 2 && c <= 5) ? 0 : 1);
      chk("wr_rd", rd_l, 1);
      if (c <= 6) begin
        chk("wr_a", ua, 3);
        chk("wr_do", udo, 8'h83);
        chk("wr_oe", oe, 1);
      end else begin
        chk("wr_oe_off", oe, 0);
      end
      if (c <= 7) chk("wr_wait", wait_h, (c == 7) ? 0 : 1);
    end

    // read LSR, data changes right before the capture edge
    nxt();
    cyc = 0;
    pe = 1'b1; WE_L = 1'b1; Address = 3'd5; UART_DataIn = 8'h11;
    #1;
    for (int c = 1; c <= 9; c++) begin
      nxt();
      if (c == 5) UART_DataIn = 8'h60;
      if (c == 6) UART_DataIn = 8'h99;
      if (c == 8) pe = 1'b0;
      #1;
      chk("rd_cs", cs_l, (c <= 6) ? 0 : 1);
      chk("rd_rd", rd_l, (c >= 2 && c <= 5) ? 0 : 1);
      chk("rd_wr", wr_l, 1);
      chk("rd_oe", oe, 0);
      if (c <= 6) chk("rd_a", ua, 5);
      if (c <= 5) chk("rd_cpu_old", cpu_dout, 0);
      if (c >= 6) chk("rd_cpu", cpu_dout, 8'h60);
      if (c <= 7) chk("rd_wait", wait_h, (c == 7) ? 0 : 1);
    end

    // back-to-back: read RBR then write SCR with enable held
    nxt();
    cyc = 0;
    pe = 1'b1; WE_L = 1'b1; Address = 3'd0; UART_DataIn = 8'hA5;
    #1;
    for (int c = 1; c <= 19; c++) begin
      nxt();
      if (c == 8) begin
        WE_L = 1'b0; CPU_DataIn = 8'h5A; Address = 3'd7;
      end
      if (c == 13) pe = 1'b0;
      #1;
      chk("bb_cs", cs_l,
          ((c <= 6) || (c >= 11 && c <= 16)) ? 0 : 1);
      chk("bb_rd", rd_l, (c >= 2 && c <= 5) ? 0 : 1);
      chk("bb_wr", wr_l, (c >= 12 && c <= 15) ? 0 : 1);
      chk("bb_oe", oe, (c >= 11 && c <= 16) ? 1 : 0);
      if (c <= 12) chk("bb_wait", wait_h, (c == 7) ? 0 : 1);
      if (c == 7 || c == 17) chk("bb_cpu", cpu_dout, 8'hA5);
      if (c >= 11 && c <= 16) begin
        chk("bb_a", ua, 7);
        chk("bb_do", udo, 8'h5A);
      end
    end

    // abort: enable drops at cycle 3; new read raised during recover
    nxt();
    cyc = 0;
    pe = 1'b1; WE_L = 1'b0; Address = 3'd1; CPU_DataIn = 8'h11;
    UART_DataIn = 8'h3C;
    #1;
    for (int c = 1; c <= 19; c++) begin
      nxt();
      if (c == 3) pe = 1'b0;
      if (c == 9) begin
        pe = 1'b1; WE_L = 1'b1; Address = 3'd2;
      end
      if (c == 18) pe = 1'b0;
      #1;
      chk("ab_wr", wr_l, (c >= 2 && c <= 5) ? 0 : 1);
      chk("ab_cs", cs_l,
          ((c <= 6) || (c >= 11 && c <= 16)) ? 0 : 1);
      chk("ab_rd", rd_l, (c >= 12 && c <= 15) ? 0 : 1);
      chk("ab_oe", oe, (c <= 6) ? 1 : 0);
      if (c <= 17)
        chk("ab_wait", wait_h,
            (c < 3) ? 1 : (c < 9) ? 0 : (c == 17) ? 0 : 1);
      if (c == 17) chk("ab_cpu", cpu_dout, 8'h3C);
    end

    // reset in the middle of a write strobe
    nxt();
    cyc = 0;
    pe = 1'b1; WE_L = 1'b0; Address = 3'd7; CPU_DataIn = 8'hFF;
    nxt();
    nxt();
    nxt();
    chk("rs_wr_low", wr_l, 0);
    chk("rs_oe_on", oe, 1);
    Reset_L = 1'b0;
    pe = 1'b0;
    nxt();
    chk("rs_cs", cs_l, 1);
    chk("rs_rd", rd_l, 1);
    chk("rs_wr", wr_l, 1);
    chk("rs_a", ua, 0);
    chk("rs_do", udo, 0);
    chk("rs_oe", oe, 0);
    chk("rs_cpu", cpu_dout, 0);
    Reset_L = 1'b1;
    nxt();
    chk("rs_idle_cs", cs_l, 1);
    pe = 1'b1; WE_L = 1'b1; Address = 3'd4; UART_DataIn = 8'h77;
    nxt();
    chk("rs_restart_cs", cs_l, 0);
    pe = 1'b0;
    for (int c = 7; c <= 15; c++) begin
      nxt();
      if (c == 12) chk("rs_cpu_rd", cpu_dout, 8'h77);
    end

    // alternate timing instance: write MCR
    nxt();
    cyc = 0;
    pe2 = 1'b1; WE_L = 1'b0; Address = 3'd4; CPU_DataIn = 8'h42;
    #1;
    chk("p2_wait0", wait2, 1);
    for (int c = 1; c <= 8; c++) begin
      nxt();
      #1;
      chk("p2_cs", cs2, (c <= 5 || c == 8) ? 0 : 1);
      if (c <= 7) begin
        chk("p2_wr", wr2, (c == 3) ? 0 : 1);
        chk("p2_rd", rd2, 1);
        chk("p2_wait", wait2, (c == 6) ? 0 : 1);
        chk("p2_oe", oe2, (c <= 5) ? 1 : 0);
      end
      if (c <= 5) begin
        chk("p2_a", ua2, 4);
        chk("p2_do", udo2, 8'h42);
      end
      if (c == 8) pe2 = 1'b0;
    end
    repeat (8) nxt();
    chk("p2_cpu", cpu_dout2, 0);
    chk("p1_quiet", cs_l, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
